// File: rtl/mult_pkg.sv
// Shared encodings for the shift-add multiplier: controller states and datapath MUX selects.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic SEL_LOAD  = 1'b0;
    localparam logic SEL_SHIFT = 1'b1;
    localparam logic SEL_CLR   = 1'b0;
    localparam logic SEL_ADD   = 1'b1;

endpackage

// File: rtl/mult_iter_cnt.sv
// Shift-add iteration counter: clears on load, counts up to WIDTH and saturates there.
module mult_iter_cnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic inc,
    output logic term
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !term) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CW'(WIDTH));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 4-bit shift-add multiplier datapath with start/busy/done handshake and abort.
// Define MULT_SEQ_CTRL_EARLY_EXIT_EN to leave RUN as soon as the B register reaches zero.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic start,
    input  logic abort,
    input  logic zero,
    input  logic lsb_b,
    output logic en_a,
    output logic ld_shift_a,
    output logic en_b,
    output logic ld_shift_b,
    output logic en_p,
    output logic ld_add_p,
    output logic busy,
    output logic done
);

`ifdef MULT_SEQ_CTRL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    state_t state;
    logic   term;
    logic   run_exit;

    assign run_exit = term | (EARLY & zero);

    mult_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (state == ST_LOAD),
        .inc   ((state == ST_RUN) && !run_exit),
        .term  (term)
    );

    // Abort overrides every transition, including a start seen in IDLE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_LOAD;
                ST_LOAD: state <= ST_RUN;
                ST_RUN:  if (run_exit) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        en_a       = 1'b0;
        ld_shift_a = SEL_LOAD;
        en_b       = 1'b0;
        ld_shift_b = SEL_LOAD;
        en_p       = 1'b0;
        ld_add_p   = SEL_CLR;
        case (state)
            ST_LOAD: begin
                en_a = 1'b1;
                en_b = 1'b1;
                en_p = 1'b1;
            end
            ST_RUN: begin
                if (!run_exit) begin
                    en_a       = 1'b1;
                    ld_shift_a = SEL_SHIFT;
                    en_b       = 1'b1;
                    ld_shift_b = SEL_SHIFT;
                    ld_add_p   = SEL_ADD;
                    en_p       = lsb_b;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state == ST_LOAD) || (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench: controller plus a behavioural shift-add datapath, WIDTH=4.
module tb_mult_seq_ctrl;

`ifdef MULT_SEQ_CTRL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr_n, start, abort, zero, lsb_b;
    logic en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done;

    logic [3:0] a_in, b_in, b_reg;
    logic [7:0] a_reg, p_reg;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .abort      (abort),
        .zero       (zero),
        .lsb_b      (lsb_b),
        .en_a       (en_a),
        .ld_shift_a (ld_shift_a),
        .en_b       (en_b),
        .ld_shift_b (ld_shift_b),
        .en_p       (en_p),
        .ld_add_p   (ld_add_p),
        .busy       (busy),
        .done       (done)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else begin
            if (en_a) a_reg <= ld_shift_a ? (a_reg << 1) : {4'b0, a_in};
            if (en_b) b_reg <= ld_shift_b ? (b_reg >> 1) : b_in;
            if (en_p) p_reg <= ld_add_p ? (p_reg + a_reg) : 8'd0;
        end
    end

    assign zero  = (b_reg == 4'd0);
    assign lsb_b = b_reg[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                          input logic [7:0] exp_p, input bit chk_ep, input string tag);
        int lat;
        int busy_cnt;
        bit got;
        logic ep_run;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        ep_run   = 1'b0;
        while (!got && lat < 20) begin
            if (busy) busy_cnt++;
            if (busy && lat >= 1) ep_run = ep_run | en_p;
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_lat);
        check({tag, " product"}, p_reg, exp_p);
        if (chk_ep) check({tag, " en_p in RUN"}, ep_run, 0);
        @(posedge clk); #1;
        check({tag, " done width"}, done, 0);
    endtask

    initial begin
        int n;
        logic seen_done;
        clr_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        check("reset outputs", {en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done}, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Basic and corner operands
        run_op(4'd3, 4'd5, EARLY ? 5 : 6, 8'd15, 1'b0, "t1 3x5");
        run_op(4'd15, 4'd15, 6, 8'd225, 1'b0, "t2 15x15");
        run_op(4'd9, 4'd0, EARLY ? 2 : 6, 8'd0, 1'b1, "t3 9x0");

        // Abort in the second RUN cycle: partial P=3 stays, no done pulse
        @(negedge clk);
        a_in = 4'd3; b_in = 4'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1;
        check("t4 abort to idle", busy, 0);
        abort = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            seen_done = seen_done | done;
            @(posedge clk); #1;
        end
        check("t4 no done after abort", seen_done, 0);
        check("t4 partial p", p_reg, 8'd3);
        run_op(4'd2, 4'd7, EARLY ? 5 : 6, 8'd14, 1'b0, "t4 2x7");

        // Async reset mid-RUN, then start masked by abort
        @(negedge clk);
        a_in = 4'd3; b_in = 4'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5 busy before clr", busy, 1);
        clr_n = 1'b0;
        #1;
        check("t5 outputs in clr", {en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done}, 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("t5 abort blocks start a", busy, 0);
        @(posedge clk); #1;
        check("t5 abort blocks start b", busy, 0);
        start = 1'b0; abort = 1'b0;

        // Start held high: one IDLE cycle between back-to-back operations
        @(negedge clk);
        a_in = 4'd3; b_in = 4'd5; start = 1'b1;
        n = 0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6 first done", done, 1);
        @(posedge clk); #1;
        check("t6 idle gap", {busy, done}, 0);
        @(posedge clk); #1;
        check("t6 restart", busy, 1);
        n = 0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6 second latency", n, EARLY ? 5 : 6);
        check("t6 second product", p_reg, 8'd15);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6 idle after release", {busy, done}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
